ifu_fetch: RTL and testbench

//   Instruction fetch unit; reads the architectural PC held by the PC unit and fetches the instruction word there.

---
 rtl/ifu_fetch.sv | 135 +++++++++++++
 tb/tb_ifu_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches the word at the architectural PC over a
// valid/ready AR/R port and hands it to decode. It fetches once per PC value,
// then waits for the PC unit's next update before fetching again.
//
// state  | meaning
// -------+------------------------------------------------------------
// INIT   | just out of reset; nothing driven, go fetch at pc_i next
// REQ    | drive AR for pc_i (misaligned pc_i goes straight to HOLD as fault)
// RESP   | request accepted, waiting for the R beat
// HOLD   | instruction (or fault) presented to decode until accepted
// WAITPC | instruction consumed, waiting for the next PC update
module ifu_fetch #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              pc_upd_i,
  output logic [PC_W-1:0]   araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [INST_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic              inst_err_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_REQ    = 3'd1,
    S_RESP   = 3'd2,
    S_HOLD   = 3'd3,
    S_WAITPC = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_pend;
  logic [INST_W-1:0]   r_inst;
  logic [PC_W-1:0]     r_inst_pc;
  logic                r_err;
  logic                r_rready;
  logic                r_ivld;
  logic                w_aligned;
  logic                w_in_req;

  assign w_aligned = (pc_i[1:0] == 2'b00);
  assign w_in_req  = (r_state == S_REQ);

  // The address follows pc_i directly so a PC update is seen without an
  // extra register stage; pc_i is stable while a request is pending.
  assign araddr_o     = w_in_req ? pc_i : '0;
  assign arvalid_o    = w_in_req & w_aligned;
  assign rready_o     = r_rready;
  assign inst_valid_o = r_ivld;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_err_o   = r_err;

  // Fetch sequencing, latched instruction and the single pending-update bit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_INIT;
      r_pend    <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_err     <= 1'b0;
      r_rready  <= 1'b0;
      r_ivld    <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (pc_upd_i) r_pend <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (pc_upd_i) r_pend <= 1'b1;
          if (!w_aligned) begin
            // Misaligned PC never reaches memory; report it as a fault word.
            r_inst_pc <= pc_i;
            r_inst    <= '0;
            r_err     <= 1'b1;
            r_ivld    <= 1'b1;
            r_state   <= S_HOLD;
          end else if (arready_i) begin
            r_inst_pc <= pc_i;
            r_rready  <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (pc_upd_i) r_pend <= 1'b1;
          if (rvalid_i) begin
            r_inst   <= rdata_i;
            r_err    <= (rresp_i != 2'b00);
            r_rready <= 1'b0;
            r_ivld   <= 1'b1;
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready_i) begin
            r_ivld <= 1'b0;
            // An update arriving with the handshake skips the WAITPC bubble.
            if (r_pend || pc_upd_i) begin
              r_pend  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_state <= S_WAITPC;
            end
          end else if (pc_upd_i) begin
            r_pend <= 1'b1;
          end
        end
        S_WAITPC: begin
          if (r_pend || pc_upd_i) begin
            r_pend  <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state  <= S_INIT;
          r_rready <= 1'b0;
          r_ivld   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table followed by
// hand-written stall sequences for the AR and decode back-pressure cases.
module tb_ifu_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_upd_i;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        upd;
    logic        ardy;
    logic        rvld;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        irdy;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rrdy;
    logic        e_ivld;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  ifu_fetch #(.PC_W(32), .INST_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .pc_upd_i     (pc_upd_i),
    .araddr_o     (araddr_o),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_err_o   (inst_err_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
  );

  function automatic vec_t mk(logic rst, logic [31:0] pc, logic upd, logic ardy,
                              logic rvld, logic [31:0] rdata, logic [1:0] rresp,
                              logic irdy, logic e_arv, logic [31:0] e_addr,
                              logic e_rrdy, logic e_ivld, logic [31:0] e_inst,
                              logic [31:0] e_ipc, logic e_err);
    vec_t v;
    v.rst = rst; v.pc = pc; v.upd = upd; v.ardy = ardy; v.rvld = rvld;
    v.rdata = rdata; v.rresp = rresp; v.irdy = irdy;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_rrdy = e_rrdy; v.e_ivld = e_ivld;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic rst, input logic [31:0] pc, input logic upd,
                       input logic ardy, input logic rvld, input logic [31:0] rdata,
                       input logic [1:0] rresp, input logic irdy);
    @(posedge clk_i);
    #1;
    rst_i = rst; pc_i = pc; pc_upd_i = upd; arready_i = ardy;
    rvalid_i = rvld; rdata_i = rdata; rresp_i = rresp; inst_ready_i = irdy;
    @(negedge clk_i);
    if (arvalid_o && arready_i) hs_cnt++;
  endtask

  initial begin
    rst_i = 1'b0; pc_i = 32'h8000_0000; pc_upd_i = 1'b0; arready_i = 1'b0;
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; inst_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);

    //            rst pc           upd ardy rvld rdata        rr irdy arv addr        rrdy ivld inst         ipc          err
    tbl.push_back(mk(0, 32'h80000000, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 32'h80000000, 0, 1, 0, 32'h0,        0, 0,  1, 32'h80000000, 0, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 1, 32'h00000413, 0, 0,  0, 32'h0,        1, 0, 32'h0,        32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h00000413, 32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000000, 1, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h00000413, 32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000004, 0, 1, 0, 32'h0,        0, 0,  1, 32'h80000004, 0, 0, 32'h00000413, 32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000004, 0, 0, 1, 32'h12345678, 2, 0,  0, 32'h0,        1, 0, 32'h00000413, 32'h80000004, 0));
    tbl.push_back(mk(1, 32'h80000004, 1, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 1, 32'h12345678, 32'h80000004, 1));
    tbl.push_back(mk(1, 32'h80000008, 0, 0, 0, 32'h0,        0, 0,  1, 32'h80000008, 0, 0, 32'h12345678, 32'h80000004, 1));
    tbl.push_back(mk(1, 32'h80000008, 0, 1, 0, 32'h0,        0, 0,  1, 32'h80000008, 0, 0, 32'h12345678, 32'h80000004, 1));
    tbl.push_back(mk(1, 32'h80000008, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        1, 0, 32'h12345678, 32'h80000008, 1));
    tbl.push_back(mk(1, 32'h80000008, 0, 0, 1, 32'h00100093, 0, 0,  0, 32'h0,        1, 0, 32'h12345678, 32'h80000008, 1));
    tbl.push_back(mk(1, 32'h80000008, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 1, 32'h00100093, 32'h80000008, 0));
    tbl.push_back(mk(1, 32'h80000008, 1, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h00100093, 32'h80000008, 0));
    tbl.push_back(mk(1, 32'h80000002, 0, 1, 0, 32'h0,        0, 0,  0, 32'h80000002, 0, 0, 32'h00100093, 32'h80000008, 0));
    tbl.push_back(mk(1, 32'h80000002, 0, 0, 0, 32'h0,        0, 1,  0, 32'h0,        0, 1, 32'h0,        32'h80000002, 1));
    tbl.push_back(mk(1, 32'h80000002, 0, 0, 1, 32'hdeadbeef, 0, 0,  0, 32'h0,        0, 0, 32'h0,        32'h80000002, 1));
    tbl.push_back(mk(1, 32'h80000002, 1, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        32'h80000002, 1));
    tbl.push_back(mk(1, 32'h8000000c, 0, 1, 0, 32'h0,        0, 0,  1, 32'h8000000c, 0, 0, 32'h0,        32'h80000002, 1));
    tbl.push_back(mk(0, 32'h8000000c, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        1, 0, 32'h0,        32'h8000000c, 1));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 32'h80000000, 0, 1, 0, 32'h0,        0, 0,  1, 32'h80000000, 0, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 1, 32'h00000413, 0, 0,  0, 32'h0,        1, 0, 32'h0,        32'h80000000, 0));
    tbl.push_back(mk(1, 32'h80000000, 0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pc, tbl[i].upd, tbl[i].ardy, tbl[i].rvld,
            tbl[i].rdata, tbl[i].rresp, tbl[i].irdy);
      chk($sformatf("v%0d arvalid", i),    32'(arvalid_o),    32'(tbl[i].e_arv));
      chk($sformatf("v%0d araddr", i),     araddr_o,          tbl[i].e_addr);
      chk($sformatf("v%0d rready", i),     32'(rready_o),     32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid_o), 32'(tbl[i].e_ivld));
      chk($sformatf("v%0d inst", i),       inst_o,            tbl[i].e_inst);
      chk($sformatf("v%0d inst_pc", i),    inst_pc_o,         tbl[i].e_ipc);
      chk($sformatf("v%0d inst_err", i),   32'(inst_err_o),   32'(tbl[i].e_err));
    end

    // Decode stalls 4 cycles in HOLD; a PC update lands during the stall.
    for (int i = 0; i < 4; i++) begin
      drive(1, (i >= 2) ? 32'h80000004 : 32'h80000000, (i == 1), 0, 0, 32'h0, 2'b00, 0);
      chk($sformatf("stall%0d inst_valid", i), 32'(inst_valid_o), 32'd1);
      chk($sformatf("stall%0d inst", i),       inst_o,            32'h00000413);
      chk($sformatf("stall%0d inst_pc", i),    inst_pc_o,         32'h80000000);
    end
    drive(1, 32'h80000004, 0, 0, 0, 32'h0, 2'b00, 1);
    chk("stall_hs inst_valid", 32'(inst_valid_o), 32'd1);

    // Pending update must refetch right away; memory then stalls AR 3 cycles.
    hs_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h80000004, 0, 0, 0, 32'h0, 2'b00, 0);
      chk($sformatf("arstall%0d arvalid", i), 32'(arvalid_o), 32'd1);
      chk($sformatf("arstall%0d araddr", i),  araddr_o,       32'h80000004);
    end
    drive(1, 32'h80000004, 0, 1, 0, 32'h0, 2'b00, 0);
    chk("ar_hs arvalid", 32'(arvalid_o), 32'd1);
    chk("ar_hs araddr",  araddr_o,       32'h80000004);
    drive(1, 32'h80000004, 0, 1, 1, 32'h00000513, 2'b00, 0);
    chk("resp arvalid", 32'(arvalid_o), 32'd0);
    chk("resp rready",  32'(rready_o),  32'd1);
    drive(1, 32'h80000004, 0, 1, 0, 32'h0, 2'b00, 1);
    chk("hold arvalid",    32'(arvalid_o),    32'd0);
    chk("hold inst_valid", 32'(inst_valid_o), 32'd1);
    chk("hold inst",       inst_o,            32'h00000513);
    chk("hold inst_pc",    inst_pc_o,         32'h80000004);
    chk("hold inst_err",   32'(inst_err_o),   32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h80000004, 0, 1, 0, 32'h0, 2'b00, 0);
      chk($sformatf("waitpc%0d arvalid", i),    32'(arvalid_o),    32'd0);
      chk($sformatf("waitpc%0d inst_valid", i), 32'(inst_valid_o), 32'd0);
    end
    chk("ar_handshake_count", 32'(hs_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
